// File: rtl/sr_hypot_pkg.sv
// sr_hypot_pkg: shared types and sizing for the hypotenuse unit.
//   HYP_W / HYP_RW / HYP_SUMW : operand, result and accumulator widths
//   HYP_*_CYCLES / HYP_LATENCY: cycle budget of one full operation
//   state_e                   : controller state encoding
// Optional feature macro: HYPOT_EARLY_EXIT_EN (FAST state is reachable only
// when it is defined).
package sr_hypot_pkg;

   localparam int HYP_W           = 8;
   localparam int HYP_RW          = HYP_W + 1;
   localparam int HYP_SUMW        = 2 * HYP_W + 1;
   localparam int HYP_SQ_CYCLES   = HYP_W;
   localparam int HYP_SQRT_CYCLES = HYP_RW;
   localparam int HYP_LATENCY     = 1 + 2 * HYP_SQ_CYCLES + HYP_SQRT_CYCLES;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQ_A = 3'd1,
      SQ_B = 3'd2,
      SQRT = 3'd3,
      FAST = 3'd4
   } state_e;

endpackage

// File: rtl/sr_hypot_unit_isqrt.sv
// sr_isqrt_seq: iterative restoring integer square root, one root bit per
// step, MSB first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture rad_i and clear remainder/root
//   step_i     : consume the top two radicand bits, produce one root bit
//   rad_i      : 2*RW-bit radicand
//   root_o     : root value after the current step (combinational), so the
//                caller can register the final root on the last step edge
module sr_isqrt_seq #(
   parameter int RW = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [2*RW-1:0] rad_i,
   output logic [RW-1:0]   root_o
);

   localparam int REMW = RW + 2;

   logic [2*RW-1:0] rad_q;
   logic [REMW-1:0] rem_q, rem_d;
   logic [RW-1:0]   root_q, root_d;
   logic [RW+3:0]   rem_sh, trial, diff;
   logic            ge;

   // Remainder never exceeds 2*root, so REMW bits hold it; the trial
   // subtrahend is 4*root+1.
   always_comb begin
      rem_sh = {rem_q, rad_q[2*RW-1 -: 2]};
      trial  = {2'b00, root_q, 2'b01};
      ge     = rem_sh >= trial;
      diff   = rem_sh - trial;
      rem_d  = REMW'(ge ? diff : rem_sh);
      root_d = {root_q[RW-2:0], ge};
   end

   assign root_o = root_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
      end else if (load_i) begin
         rad_q  <= rad_i;
         rem_q  <= '0;
         root_q <= '0;
      end else if (step_i) begin
         rad_q  <= rad_q << 2;
         rem_q  <= rem_d;
         root_q <= root_d;
      end
   end

endmodule

// File: rtl/sr_hypot_unit.sv
// sr_hypot_unit: multi-cycle floor(sqrt(a*a + b*b)) for the CPU execute path.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin operation, sampled only in IDLE (with a, b)
//   a, b        : unsigned W-bit operands
//   result      : RW-bit root, updated at completion, otherwise held
//   busy        : high from the start cycle until completion (combinational)
//   done        : one-cycle pulse in the first cycle busy reads low again
//   dbg_state_o : current controller state, for debug/checkers
// Handshake: start acts as a request that is taken in any cycle the unit is
// IDLE; busy is asserted in that same cycle so the CPU stalls its PC at once,
// and starts seen while busy from an earlier request are dropped.
// Optional macro HYPOT_EARLY_EXIT_EN: a zero operand bypasses the squaring
// and root phases through the FAST state (result = max(a,b), 2 busy cycles).
module sr_hypot_unit
   import sr_hypot_pkg::*;
#(
   parameter int W  = HYP_W,
   parameter int RW = W + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic [RW-1:0] result,
   output logic          busy,
   output logic          done,
   output state_e        dbg_state_o
);

   localparam int SUMW = 2 * W + 1;
   localparam int RADW = 2 * RW;
   localparam int CW   = $clog2(RW);
   localparam logic [CW-1:0] SQ_LAST = CW'(W - 1);
   localparam logic [CW-1:0] RT_LAST = CW'(RW - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, opnd;
   logic [SUMW-1:0] sum_q, sum_d, addend;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [RW-1:0]  result_q, result_d, root_nxt;
   logic           done_q, done_d;
   logic           rt_load, rt_step, sq_last, rt_last, opnd_bit;
   logic [RADW-1:0] rad;

   assign sq_last = (cnt_q == SQ_LAST);
   assign rt_last = (cnt_q == RT_LAST);

`ifdef HYPOT_EARLY_EXIT_EN
   logic zero_op;
   assign zero_op = (a == '0) || (b == '0);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) begin
`ifdef HYPOT_EARLY_EXIT_EN
            state_d = zero_op ? FAST : SQ_A;
`else
            state_d = SQ_A;
`endif
         end
         SQ_A:    if (sq_last) state_d = SQ_B;
         SQ_B:    if (sq_last) state_d = SQRT;
         SQRT:    if (rt_last) state_d = IDLE;
         FAST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shift-add squaring: cycle k adds (op << k) when bit k of op is set.
   always_comb begin
      opnd     = (state_q == SQ_B) ? b_q : a_q;
      opnd_bit = |(opnd & (W'(1) << cnt_q));
      addend   = opnd_bit ? (SUMW'(opnd) << cnt_q) : '0;
   end

   // Datapath / output logic
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      rt_load  = 1'b0;
      rt_step  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            a_d   = a;
            b_d   = b;
            sum_d = '0;
            cnt_d = '0;
         end
         SQ_A: begin
            sum_d = sum_q + addend;
            cnt_d = sq_last ? '0 : cnt_q + 1'b1;
         end
         SQ_B: begin
            sum_d = sum_q + addend;
            cnt_d = sq_last ? '0 : cnt_q + 1'b1;
            // Load the root engine with the final sum so SQRT starts at once.
            rt_load = sq_last;
         end
         SQRT: begin
            rt_step = 1'b1;
            cnt_d   = rt_last ? '0 : cnt_q + 1'b1;
            if (rt_last) begin
               result_d = root_nxt;
               done_d   = 1'b1;
            end
         end
`ifdef HYPOT_EARLY_EXIT_EN
         FAST: begin
            result_d = RW'((a_q > b_q) ? a_q : b_q);
            done_d   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign rad = RADW'(sum_d);

   sr_isqrt_seq #(.RW(RW)) u_isqrt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (rt_load),
      .step_i (rt_step),
      .rad_i  (rad),
      .root_o (root_nxt)
   );

   assign busy        = (state_q != IDLE) | start;
   assign done        = done_q;
   assign result      = result_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sr_hypot_unit.sv
// tb_sr_hypot_unit: directed + randomized bench for sr_hypot_unit.
// Reference: floor(sqrt(a^2+b^2)) computed by plain integer search.
module tb_sr_hypot_unit;
   import sr_hypot_pkg::*;

   localparam int FULL_LAT = 26;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [8:0] result;
   logic       busy;
   logic       done;
   state_e     dbg_state;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];
   logic [8:0] last_res;

   // Clock / reset
   always #5 clk = ~clk;

   sr_hypot_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .result      (result),
      .busy        (busy),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   function automatic int ref_hypot(input int x, input int y);
      int s;
      int r;
      s = x * x + y * y;
      r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Driver: called aligned just after a negedge; that cycle is cycle 0.
   // inject_at > 0 re-asserts start (a=9,b=12) mid-operation, which must be
   // ignored. chain asserts the next start (na,nb) in the done cycle.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input int inject_at, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb);
      int lat;
      lat = FULL_LAT;
`ifdef HYPOT_EARLY_EXIT_EN
      if (ta == 0 || tb_v == 0) lat = 2;
`endif
      exp_q.push_back(9'(ref_hypot(int'(ta), int'(tb_v))));
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      #1;
      check("busy_cycle0", busy, 1);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            a     = 8'($urandom_range(0, 255));
            b     = 8'($urandom_range(0, 255));
         end
         if (inject_at > 0 && inject_at < lat - 1) begin
            if (c == inject_at) begin
               start = 1'b1;
               a     = 8'd9;
               b     = 8'd12;
            end
            if (c == inject_at + 1) start = 1'b0;
         end
         if (c < lat) begin
            #1;
            check("busy_mid", busy, 1);
            check("done_mid", done, 0);
         end else begin
            if (chain) begin
               start = 1'b1;
               a     = na;
               b     = nb;
            end
            #1;
            check("busy_done_cycle", busy, 32'(chain));
            check("done_pulse", done, 1);
            last_res = exp_q.pop_front();
            check("result", result, last_res);
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_result_hold", result, last_res);
      end
   endtask

   initial begin
      logic [7:0] ra, rb, na, nb;
      int inj;
      bit chn;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", dbg_state, IDLE);
      @(negedge clk);
      rst_n    = 1'b1;
      last_res = '0;

      // Directed: 3/4 with an ignored restart at cycle 10
      @(negedge clk);
      run_op(8'd3, 8'd4, 10, 1'b0, 8'd0, 8'd0);
      idle_cycles(2);

      // Corner values
      @(negedge clk);
      run_op(8'd255, 8'd255, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);
      @(negedge clk);
      run_op(8'd1, 8'd1, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);
      @(negedge clk);
      run_op(8'd0, 8'd0, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);

      // Back-to-back: 3/4 then 6/8 started in the done cycle
      @(negedge clk);
      run_op(8'd3, 8'd4, 0, 1'b1, 8'd6, 8'd8);
      run_op(8'd6, 8'd8, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);

      // Asynchronous reset mid-operation (cycle 15)
      @(negedge clk);
      start = 1'b1;
      a     = 8'd3;
      b     = 8'd4;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_result", result, 0);
      check("abort_done", done, 0);
      check("abort_state", dbg_state, IDLE);
      @(negedge clk);
      rst_n    = 1'b1;
      last_res = '0;
      idle_cycles(1);
      @(negedge clk);
      run_op(8'd5, 8'd12, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);

      // Zero-operand and full-path cases (latency depends on build)
      @(negedge clk);
      run_op(8'd0, 8'd200, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);
      @(negedge clk);
      run_op(8'd7, 8'd24, 0, 1'b0, 8'd0, 8'd0);
      idle_cycles(1);

      // Randomized operations, some chained, some with ignored restarts
      @(negedge clk);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      for (int i = 0; i < 10; i++) begin
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0;
         chn = (i < 9) && ($urandom_range(0, 1) == 1);
         na  = (i == 4) ? 8'd0 : 8'($urandom_range(0, 255));
         nb  = 8'($urandom_range(0, 255));
         run_op(ra, rb, inj, chn, na, nb);
         if (!chn) begin
            idle_cycles(1);
            @(negedge clk);
         end
         ra = na;
         rb = nb;
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_hypot_unit.md
Name: sr_hypot_unit

Overview:
Multi-cycle arithmetic unit attached to the single-cycle CPU's execute path. It computes floor(sqrt(a*a + b*b)) for two unsigned register operands.
- Produces a 9-bit result that the CPU writes back through its wide write-data mux source (wdSrc = 2'b10).
- Stalls the PC via a start/busy handshake until the result is ready.
- Fully self-contained: does not borrow the CPU ALU.

Parameters:
W, 8, operand width in bits (a, b taken from rs1/rs2 low bits).
RW, W+1, result width; must cover sqrt(2*(2^W-1)^2).

Ports:
clk     in   1    system clock
rst_n   in   1    asynchronous active-low reset
start   in   1    begin operation; sampled only in IDLE
a       in   W    operand A (unsigned), sampled with start
b       in   W    operand B (unsigned), sampled with start
result  out  RW   floor(sqrt(a^2+b^2)); held stable until next accepted start
busy    out  1    high while operation in progress, including the start cycle
done    out  1    one-cycle pulse in the cycle busy first reads low after completion

Behaviour:
- Reset: clk and rst_n as named, one clock domain; reset is asynchronous and active-low. Asserting rst_n=0 forces state=IDLE, result=0, done=0, and clears all internal registers; it aborts any operation in flight.
- busy = (state != IDLE) | (state == IDLE & start). This is combinational, so the CPU stalls the PC in the same cycle it asserts start.
- States:
  - IDLE: on start, latch a, b; clear accumulator; go to SQ_A.
  - SQ_A: W cycles of shift-add accumulating a*a into a 2W+1-bit sum.
  - SQ_B: W cycles adding b*b into the same sum.
  - SQRT: RW cycles of restoring digit-by-digit integer square root on the sum, zero-padded to 2*RW bits. Each cycle produces one root bit, MSB first.
  - Last SQRT cycle: register root into result; go to IDLE; done=1 the following cycle.
- Latency with W=8:
  - busy is high for 1 + 8 + 8 + 9 = 26 consecutive cycles (start cycle = cycle 0).
  - result is valid and done=1 in cycle 26.
- Start while state != IDLE is ignored; no queuing.
- Start asserted in the same cycle done pulses is accepted, giving back-to-back operation.
- Operands are not re-sampled after cycle 0; a/b changes mid-operation have no effect.
- Width rule: sum max = 2*(2^W-1)^2 < 2^(2W+1); no overflow is allowed. Root fits in RW bits (W=8: max 360).

Optional Feature:
HYPOT_EARLY_EXIT_EN.
- Defined: in IDLE with start, if a==0 or b==0, skip squaring/sqrt. Result = max(a,b) is registered at end of cycle 1; busy is high cycles 0..1 only; done=1 in cycle 2. This path uses an extra state FAST.
- Undefined: every operation takes the full 26-cycle path, including zero operands.

Decomposition:
- Package sr_hypot_pkg:
  - state enum (IDLE, SQ_A, SQ_B, SQRT, FAST);
  - localparams for W, RW, SUMW = 2W+1, and cycle counts.
- One sub-module, sr_isqrt_seq: iterative root engine with load/step inputs and a root output, 2*RW-bit radicand. Squaring stays inline in sr_hypot_unit.

Test Plan:
- a=3, b=4, single start pulse -> busy high exactly 26 cycles, done pulse in cycle 26, result=5.
- a=255, b=255 -> result=360 (sum 130050); a=1, b=1 -> result=1; a=0, b=0 -> result=0 (26 cycles without HYPOT_EARLY_EXIT_EN).
- Start re-asserted at cycle 10 with a=9, b=12 during a 3/4 operation -> ignored; result=5.
- Back-to-back: second start (a=6, b=8) in the done cycle -> accepted; busy stays high; second result=10 in cycle 52.
- rst_n dropped at cycle 15 of an operation -> immediately state IDLE, busy=0 (start low), result=0; a following start with a=5, b=12 -> result=13.
- With HYPOT_EARLY_EXIT_EN: a=0, b=200 -> busy cycles 0..1, done in cycle 2, result=200; a=7, b=24 -> full path, result=25.
